// File: rtl/ahblite_bram_ctrl_pkg.sv
// Shared definitions for the AHB-Lite to block-RAM controller.
// Holds the AHB transfer-type, transfer-size and response codes plus the
// encoding of the response state machine.
package ahblite_bram_ctrl_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'd0;
    localparam logic [2:0] HSIZE_HALF = 3'd1;
    localparam logic [2:0] HSIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        RESP_OKAY = 2'd0,
        RESP_ERR1 = 2'd1,
        RESP_ERR2 = 2'd2
    } resp_state_t;

endpackage

// File: rtl/ahblite_bram_ctrl_mask.sv
// ahb_byte_mask: combinational byte-lane decoder.
// Ports:
//   hsize   in  3  AHB transfer size
//   addr_lo in  2  byte address bits [1:0]
//   mask    out 4  byte lanes touched by the transfer
//   illegal out 1  size unsupported or address misaligned for the size
module ahb_byte_mask
    import ahblite_bram_ctrl_pkg::*;
(
    input  logic [2:0] hsize,
    input  logic [1:0] addr_lo,
    output logic [3:0] mask,
    output logic       illegal
);

    always_comb begin
        mask    = 4'b0000;
        illegal = 1'b0;
        case (hsize)
            HSIZE_BYTE: mask = 4'b0001 << addr_lo;
            HSIZE_HALF: begin
                mask    = 4'b0011 << {addr_lo[1], 1'b0};
                illegal = addr_lo[0];
            end
            HSIZE_WORD: begin
                mask    = 4'b1111;
                illegal = (addr_lo != 2'b00);
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahblite_bram_ctrl.sv
// ahblite_bram_ctrl: AHB-Lite slave in front of a simple dual-port BRAM
// (port A write, port B registered read). Zero wait states for legal
// transfers, two-cycle ERROR response for illegal ones.
//
// state | meaning
// ------+---------------------------------------------------------
// OKAY  | normal operation, HREADYOUT=1, HRESP=OKAY
// ERR1  | first error cycle, HREADYOUT=0, HRESP=ERROR
// ERR2  | second error cycle, HREADYOUT=1, HRESP=ERROR
//
// Ports:
//   HCLK, HRESET                     clock, async active-high reset
//   HSEL/HADDR/HTRANS/HSIZE/HWRITE   address phase
//   HWDATA                           write data (data phase)
//   HREADY                           bus ready in
//   HREADYOUT/HRESP/HRDATA           slave response
//   BRAM_ADDRA/BRAM_WE/BRAM_WDATA    BRAM write port
//   BRAM_ADDRB/BRAM_RDATA            BRAM read port (1-cycle read latency)
module ahblite_bram_ctrl
    import ahblite_bram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  HSEL,
    input  logic [31:0]           HADDR,
    input  logic [1:0]            HTRANS,
    input  logic [2:0]            HSIZE,
    input  logic                  HWRITE,
    input  logic [31:0]           HWDATA,
    input  logic                  HREADY,
    output logic                  HREADYOUT,
    output logic                  HRESP,
    output logic [31:0]           HRDATA,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDRA,
    output logic [3:0]            BRAM_WE,
    output logic [31:0]           BRAM_WDATA,
    output logic [ADDR_WIDTH-1:0] BRAM_ADDRB,
    input  logic [31:0]           BRAM_RDATA
);

    resp_state_t           state_q, state_d;
    logic                  dp_write_q, dp_write_d;
    logic                  dp_read_q, dp_read_d;
    logic [ADDR_WIDTH-1:0] dp_addr_q, dp_addr_d;
    logic [3:0]            dp_mask_q, dp_mask_d;
    logic                  fwd_valid_q, fwd_valid_d;
    logic [ADDR_WIDTH-1:0] fwd_addr_q, fwd_addr_d;
    logic [31:0]           fwd_data_q, fwd_data_d;
    logic [3:0]            fwd_mask_q, fwd_mask_d;

    logic                  accept;
    logic                  legal_accept;
    logic [3:0]            ap_mask;
    logic                  ap_illegal;
    logic [ADDR_WIDTH-1:0] ap_word;
    logic                  fwd_hit;

    // Upper address bits alias onto the BRAM; HTRANS[0] only separates
    // NONSEQ from SEQ, which this slave treats identically.
    logic unused_bits;
    assign unused_bits = ^{HADDR[31:ADDR_WIDTH+2], HADDR[1:0] == 2'b00 ? 1'b0 : 1'b0, HTRANS[0]};

    assign ap_word      = HADDR[ADDR_WIDTH+1:2];
    assign accept       = HSEL & HREADY & HTRANS[1];
    assign legal_accept = accept & ~ap_illegal;

    ahb_byte_mask u_mask (
        .hsize   (HSIZE),
        .addr_lo (HADDR[1:0]),
        .mask    (ap_mask),
        .illegal (ap_illegal)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            RESP_OKAY: if (accept && ap_illegal) state_d = RESP_ERR1;
            RESP_ERR1: state_d = RESP_ERR2;
            RESP_ERR2: state_d = (accept && ap_illegal) ? RESP_ERR1 : RESP_OKAY;
            default:   state_d = RESP_OKAY;
        endcase
    end

    always_comb begin
        dp_write_d  = dp_write_q;
        dp_read_d   = dp_read_q;
        dp_addr_d   = dp_addr_q;
        dp_mask_d   = dp_mask_q;
        fwd_valid_d = fwd_valid_q;
        fwd_addr_d  = fwd_addr_q;
        fwd_data_d  = fwd_data_q;
        fwd_mask_d  = fwd_mask_q;
        // Data-phase flags only advance when the bus completes a phase;
        // an illegal transfer leaves no data phase behind.
        if (HREADY) begin
            dp_write_d = legal_accept & HWRITE;
            dp_read_d  = legal_accept & ~HWRITE;
            if (accept) begin
                dp_addr_d = ap_word;
                dp_mask_d = ap_mask;
            end
            // Remember the write that lands on this edge so a read issued
            // on the same edge can override BRAM's read-old-data result.
            if (dp_write_q) begin
                fwd_valid_d = 1'b1;
                fwd_addr_d  = dp_addr_q;
                fwd_data_d  = HWDATA;
                fwd_mask_d  = dp_mask_q;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q     <= RESP_OKAY;
            dp_write_q  <= 1'b0;
            dp_read_q   <= 1'b0;
            dp_addr_q   <= '0;
            dp_mask_q   <= 4'b0000;
            fwd_valid_q <= 1'b0;
            fwd_addr_q  <= '0;
            fwd_data_q  <= 32'h0;
            fwd_mask_q  <= 4'b0000;
        end else begin
            state_q     <= state_d;
            dp_write_q  <= dp_write_d;
            dp_read_q   <= dp_read_d;
            dp_addr_q   <= dp_addr_d;
            dp_mask_q   <= dp_mask_d;
            fwd_valid_q <= fwd_valid_d;
            fwd_addr_q  <= fwd_addr_d;
            fwd_data_q  <= fwd_data_d;
            fwd_mask_q  <= fwd_mask_d;
        end
    end

    assign HREADYOUT  = (state_q != RESP_ERR1);
    assign HRESP      = (state_q == RESP_OKAY) ? HRESP_OKAY : HRESP_ERROR;

    assign BRAM_WE    = dp_write_q ? dp_mask_q : 4'b0000;
    assign BRAM_ADDRA = dp_addr_q;
    assign BRAM_WDATA = HWDATA;
    assign BRAM_ADDRB = ap_word;

    assign fwd_hit = fwd_valid_q && (fwd_addr_q == dp_addr_q);

    always_comb begin
        HRDATA = 32'h0;
        if (dp_read_q) begin
            for (int n = 0; n < 4; n++) begin
                HRDATA[8*n +: 8] = (fwd_hit && fwd_mask_q[n]) ? fwd_data_q[8*n +: 8]
                                                              : BRAM_RDATA[8*n +: 8];
            end
        end
    end

endmodule

// File: tb/tb_ahblite_bram_ctrl.sv
module tb_ahblite_bram_ctrl;

    localparam int AW = 10;
    localparam int NW = 1 << AW;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic          HSEL;
    logic [31:0]   HADDR;
    logic [1:0]    HTRANS;
    logic [2:0]    HSIZE;
    logic          HWRITE;
    logic [31:0]   HWDATA;
    logic          HREADY;
    logic          HREADYOUT;
    logic          HRESP;
    logic [31:0]   HRDATA;
    logic [AW-1:0] BRAM_ADDRA;
    logic [3:0]    BRAM_WE;
    logic [31:0]   BRAM_WDATA;
    logic [AW-1:0] BRAM_ADDRB;
    logic [31:0]   BRAM_RDATA;

    logic [31:0]   bram_mem [NW];
    logic [31:0]   ref_mem  [NW];
    logic          init_en;
    logic          bd_en;
    logic [AW-1:0] bd_addr;
    logic [31:0]   bd_data;

    int total = 0;
    int bad   = 0;

    // Spec-level bus model: the transfer currently in its data phase and
    // the number of ERROR-response cycles still owed.
    logic          pend_valid;
    logic          pend_write;
    logic [31:0]   pend_addr;
    logic [2:0]    pend_size;
    logic [31:0]   pend_wdata;
    int            err_cnt;

    always #5 HCLK = ~HCLK;

    // Single slave on the bus: the interconnect returns our own ready.
    assign HREADY = HREADYOUT;

    ahblite_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .HSEL       (HSEL),
        .HADDR      (HADDR),
        .HTRANS     (HTRANS),
        .HSIZE      (HSIZE),
        .HWRITE     (HWRITE),
        .HWDATA     (HWDATA),
        .HREADY     (HREADY),
        .HREADYOUT  (HREADYOUT),
        .HRESP      (HRESP),
        .HRDATA     (HRDATA),
        .BRAM_ADDRA (BRAM_ADDRA),
        .BRAM_WE    (BRAM_WE),
        .BRAM_WDATA (BRAM_WDATA),
        .BRAM_ADDRB (BRAM_ADDRB),
        .BRAM_RDATA (BRAM_RDATA)
    );

    function automatic logic [31:0] init_word(input int i);
        return 32'h5A00_0000 ^ (i * 32'h0001_0307);
    endfunction

    // BRAM: byte-write port A, registered read port B returning old data.
    always @(posedge HCLK) begin
        if (init_en) begin
            for (int i = 0; i < NW; i++) bram_mem[i] <= init_word(i);
        end else begin
            for (int n = 0; n < 4; n++)
                if (BRAM_WE[n]) bram_mem[BRAM_ADDRA][8*n +: 8] <= BRAM_WDATA[8*n +: 8];
            if (bd_en) bram_mem[bd_addr] <= bd_data;
        end
        BRAM_RDATA <= bram_mem[BRAM_ADDRB];
    end

    function automatic logic legal_f(input logic [2:0] sz, input logic [31:0] a);
        if (sz > 3'd2) return 1'b0;
        return (int'(a[1:0]) % (1 << int'(sz))) == 0;
    endfunction

    function automatic logic [3:0] mask_f(input logic [2:0] sz, input logic [31:0] a);
        logic [3:0] m;
        int nb;
        int lo;
        m  = 4'b0000;
        nb = 1 << int'(sz);
        lo = int'(a[1:0]);
        for (int b = 0; b < 4; b++)
            if (b >= lo && b < lo + nb) m[b] = 1'b1;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One bus cycle; entered and left at posedge+1.
    task automatic cycle(input logic sel, input logic [1:0] trans, input logic wr,
                         input logic [2:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd, output logic taken);
        logic       exp_rdy;
        logic       exp_resp;
        logic       acc;
        logic       leg;
        logic [3:0] m;
        HSEL   = sel;
        HTRANS = trans;
        HWRITE = wr;
        HSIZE  = sz;
        HADDR  = addr;
        HWDATA = pend_wdata;
        #1;
        exp_rdy  = (err_cnt != 2);
        exp_resp = (err_cnt != 0);
        chk("hreadyout", 32'(HREADYOUT), 32'(exp_rdy));
        chk("hresp", 32'(HRESP), 32'(exp_resp));
        chk("bram_addrb", 32'(BRAM_ADDRB), 32'(addr[AW+1:2]));
        if (pend_valid && pend_write) begin
            m = mask_f(pend_size, pend_addr);
            chk("bram_we", 32'(BRAM_WE), 32'(m));
            chk("bram_addra", 32'(BRAM_ADDRA), 32'(pend_addr[AW+1:2]));
            chk("bram_wdata", BRAM_WDATA, pend_wdata);
            for (int b = 0; b < 4; b++)
                if (m[b]) ref_mem[pend_addr[AW+1:2]][8*b +: 8] = pend_wdata[8*b +: 8];
        end else begin
            chk("bram_we_idle", 32'(BRAM_WE), 32'h0);
        end
        if (pend_valid && !pend_write)
            chk("hrdata", HRDATA, ref_mem[pend_addr[AW+1:2]]);
        else
            chk("hrdata_idle", HRDATA, 32'h0);
        taken = exp_rdy;
        acc   = exp_rdy && sel && trans[1];
        leg   = legal_f(sz, addr);
        if (exp_rdy) begin
            if (acc && !leg)      err_cnt = 2;
            else if (err_cnt > 0) err_cnt = err_cnt - 1;
            pend_valid = acc && leg;
            pend_write = wr;
            pend_addr  = addr;
            pend_size  = sz;
            pend_wdata = wd;
        end else begin
            err_cnt = 1;
        end
        @(posedge HCLK);
        #1;
    endtask

    // Present an address phase until the bus samples it (bounded).
    task automatic xfer(input logic sel, input logic [1:0] trans, input logic wr,
                        input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] wd);
        logic taken;
        taken = 1'b0;
        for (int k = 0; k < 4 && !taken; k++) cycle(sel, trans, wr, sz, addr, wd, taken);
    endtask

    task automatic wr_t(input logic [2:0] sz, input logic [31:0] addr, input logic [31:0] wd);
        xfer(1'b1, 2'b10, 1'b1, sz, addr, wd);
    endtask

    task automatic rd_t(input logic [2:0] sz, input logic [31:0] addr);
        xfer(1'b1, 2'b10, 1'b0, sz, addr, 32'h0);
    endtask

    task automatic idle();
        logic taken;
        cycle(1'b0, 2'b00, 1'b0, 3'd0, 32'h0, 32'h0, taken);
    endtask

    initial begin
        HRESET = 1'b1;
        HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0;
        HADDR = 32'h0; HWDATA = 32'h0;
        init_en = 1'b1; bd_en = 1'b0; bd_addr = '0; bd_data = 32'h0;
        pend_valid = 1'b0; pend_write = 1'b0; pend_addr = 32'h0;
        pend_size = 3'd0; pend_wdata = 32'h0; err_cnt = 0;
        for (int i = 0; i < NW; i++) ref_mem[i] = init_word(i);
        @(posedge HCLK);
        #1;
        init_en = 1'b0;
        chk("rst_hreadyout", 32'(HREADYOUT), 32'h1);
        chk("rst_hresp", 32'(HRESP), 32'h0);
        chk("rst_hrdata", HRDATA, 32'h0);
        chk("rst_bram_we", 32'(BRAM_WE), 32'h0);
        HRESET = 1'b0;

        // Word write then back-to-back read through the forwarding path.
        wr_t(3'd2, 32'h100, 32'hDEAD_BEEF);
        rd_t(3'd2, 32'h100);
        idle();

        // Byte write into lane 3.
        wr_t(3'd2, 32'h100, 32'h1122_3344);
        idle();
        wr_t(3'd0, 32'h103, 32'hAA00_0000);
        idle();
        rd_t(3'd2, 32'h100);
        idle();

        // Halfword write, immediate read: only lanes 3:2 come from forwarding.
        wr_t(3'd1, 32'h102, 32'h5566_0000);
        rd_t(3'd1, 32'h102);
        idle();

        // Misaligned word write: error response, no BRAM write.
        wr_t(3'd2, 32'h101, 32'hFFFF_FFFF);
        idle();
        idle();
        rd_t(3'd2, 32'h100);
        idle();

        // Two illegal transfers back to back, then recovery.
        wr_t(3'd1, 32'h105, 32'h1234_5678);
        rd_t(3'd3, 32'h104);
        idle();
        idle();

        // Upper address bits alias onto the same word.
        wr_t(3'd2, 32'h8000_0108, 32'hCAFE_0108);
        idle();
        rd_t(3'd2, 32'h0000_0108);
        idle();

        // Reset during a write data phase aborts it and clears forwarding.
        wr_t(3'd2, 32'h10C, 32'h1111_1111);
        idle();
        wr_t(3'd2, 32'h10C, 32'h2222_2222);
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = pend_wdata;
        #1;
        HRESET = 1'b1;
        #1;
        chk("midrst_bram_we", 32'(BRAM_WE), 32'h0);
        chk("midrst_hreadyout", 32'(HREADYOUT), 32'h1);
        chk("midrst_hresp", 32'(HRESP), 32'h0);
        chk("midrst_hrdata", HRDATA, 32'h0);
        pend_valid = 1'b0;
        err_cnt = 0;
        @(posedge HCLK);
        #1;
        HRESET = 1'b0;
        idle();
        bd_addr = AW'(32'h10C >> 2);
        bd_data = 32'h3333_CAFE;
        bd_en = 1'b1;
        ref_mem[32'h10C >> 2] = 32'h3333_CAFE;
        idle();
        bd_en = 1'b0;
        rd_t(3'd2, 32'h10C);
        idle();

        // Randomized traffic over four words with random aliasing bits.
        for (int t = 0; t < 400; t++) begin
            logic        sel;
            logic [1:0]  trans;
            logic        wr;
            logic [2:0]  sz;
            logic [31:0] addr;
            logic [31:0] wd;
            sel   = ($urandom_range(0, 7) != 0);
            trans = 2'($urandom_range(0, 3));
            wr    = 1'($urandom_range(0, 1));
            sz    = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            addr  = ($urandom << (AW + 2)) | (32'h100 + 32'(4 * $urandom_range(0, 3)) + 32'($urandom_range(0, 3)));
            wd    = $urandom;
            xfer(sel, trans, wr, sz, addr, wd);
        end
        idle();
        idle();
        idle();

        for (int i = 32'h100 >> 2; i <= (32'h10C >> 2); i++)
            chk("mem_final", bram_mem[i], ref_mem[i]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ahblite_bram_ctrl.md
AHBLITE_BRAM_CTRL -- requirements
Module: ahblite_bram_ctrl

Interface
REQ-001 Parameter: ADDR_WIDTH, default 14, BRAM word-address width (memory = 2**ADDR_WIDTH 32-bit words).
REQ-002 HCLK  in  1  single clock for all logic; rising edge.
REQ-003 HRESET  in  1  reset, asynchronous, active-high.
REQ-004 HSEL  in  1  slave select.
REQ-005 HADDR  in  32  byte address; bits [ADDR_WIDTH+1:2] select the word.
REQ-006 HTRANS  in  2  transfer type; NONSEQ(2)/SEQ(3) valid, IDLE(0)/BUSY(1) ignored.
REQ-007 HSIZE  in  3  0=byte, 1=halfword, 2=word.
REQ-008 HWRITE  in  1  1=write.
REQ-009 HWDATA  in  32  write data, data phase.
REQ-010 HREADY  in  1  bus-level ready; address phase accepted only when high.
REQ-011 HREADYOUT  out  1  slave ready.
REQ-012 HRESP  out  1  0=OKAY, 1=ERROR.
REQ-013 HRDATA  out  32  read data, data phase.
REQ-014 BRAM_ADDRA  out  ADDR_WIDTH  write word address.
REQ-015 BRAM_WE  out  4  per-byte write enable.
REQ-016 BRAM_WDATA  out  32  write data.
REQ-017 BRAM_ADDRB  out  ADDR_WIDTH  read word address.
REQ-018 BRAM_RDATA  in  32  read data, registered by BRAM one cycle after BRAM_ADDRB.

Function
REQ-019 Accepted transfer = HSEL & HREADY & HTRANS[1]; all address-phase signals registered on that edge.
REQ-020 Illegal transfer = HSIZE>2, or halfword with HADDR[0]=1, or word with HADDR[1:0]!=0.
REQ-021 Byte mask from registered HSIZE/HADDR[1:0]: byte -> 1<<addr[1:0]; halfword -> 4'b0011<<(2*addr[1]); word -> 4'b1111.
REQ-022 Write data phase (legal write accepted previous edge): BRAM_WE = mask, BRAM_ADDRA = registered word address, BRAM_WDATA = HWDATA, all combinational; zero wait states.
REQ-023 BRAM_WE = 0 in every cycle that is not a legal write data phase, including error states.
REQ-024 BRAM_ADDRB = HADDR[ADDR_WIDTH+1:2] combinationally, so read data is available in the data phase; legal reads zero wait states.
REQ-025 Forwarding register (valid, word address, data, mask) loaded at end of every legal write data phase; cleared only by reset.
REQ-026 Read data phase: HRDATA byte n = forward data byte n if valid & address match & mask[n], else BRAM_RDATA byte n (covers BRAM read-old-data on write-then-read).
REQ-027 HRDATA outside a read data phase = 32'h0.
REQ-028 Response FSM states OKAY, ERR1, ERR2; OKAY: HREADYOUT=1, HRESP=0.
REQ-029 OKAY -> ERR1 when an illegal transfer is accepted; ERR1: HREADYOUT=0, HRESP=1; ERR1 -> ERR2 unconditionally; ERR2: HREADYOUT=1, HRESP=1; ERR2 -> OKAY, or ERR1 if a new illegal transfer is accepted on the same edge.
REQ-030 An illegal write never asserts BRAM_WE; an illegal read returns HRDATA=0.
REQ-031 Transfer accepted while in ERR2 is handled normally; none is accepted in ERR1 (HREADY low).
REQ-032 Address bits above ADDR_WIDTH+1 ignored (aliasing); no error.

Reset
REQ-033 On HRESET high, asynchronously: FSM=OKAY, HREADYOUT=1, HRESP=0, HRDATA=0, BRAM_WE=0, data-phase flags=0, forwarding valid=0.
REQ-034 Reset asserted mid-transfer aborts it; no BRAM write is issued in the reset cycle or first cycle after release.

Structure
REQ-035 Shared package holds HTRANS codes, HSIZE codes, HRESP codes and FSM state encodings.
REQ-036 One sub-module, ahb_byte_mask (HSIZE + addr[1:0] -> mask + illegal flag), combinational; remainder flat.

Verification
REQ-037 Word write 0x100 <- 32'hDEADBEEF, then word read 0x100 back-to-back -> BRAM_WE=4'hF in write data phase; HRDATA=32'hDEADBEEF via forwarding, HREADYOUT=1 throughout.
REQ-038 Byte write 0x103 <- 8'hAA over word 32'h11223344 -> BRAM_WE=4'b1000; subsequent word read 32'hAA223344.
REQ-039 Halfword write 0x102 <- 16'h5566 immediately followed by read 0x102 -> read returns 32'h55663344 with only bytes 3:2 forwarded.
REQ-040 Word write to 0x101 -> HREADYOUT 0 then 1 with HRESP=1 for both cycles, BRAM_WE=0 throughout, memory unchanged.
REQ-041 Two illegal transfers back-to-back -> ERR1,ERR2,ERR1,ERR2 sequence, then OKAY.
REQ-042 HRESET pulsed during write data phase -> BRAM_WE drops to 0 immediately, all outputs at reset values, forwarding valid cleared.
